stage_id_fwd: RTL

Parametrised operand-fetch and ID/EXE pipeline stage for the MIPS core. It sits between the instruction decoder and the execute stage. It resolves rs/rt operands by forwarding from FWD_STAGES downstream pipeline stages, detects load-use hazards and inserts bubbles. It registers the resolved operands, destination and opaque decoded control into the ID/EXE slot under a valid/ready handshake with flush.

---
 rtl/stage_id_fwd.sv | 112 +++++++++++
 1 files changed

// File: rtl/stage_id_fwd.sv
// rtl/stage_id_fwd.sv - operand fetch with forwarding, load-use stall and ID/EXE slot
//
// Resolves rs/rt operands from FWD_STAGES downstream writers (index 0 youngest)
// or the register file, stalls on a load-use dependency, and registers the
// resolved operands, destination and opaque control into the ID/EXE slot.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                decoded instruction handshake
//   in_rs, in_rt, in_use_rs/rt       source addresses and use flags
//   in_rfwa, in_ctrl                 destination and decoded control
//   rf_rd1, rf_rd2                   register file read data
//   fwd_we/wa/wd/ld                  per-stage write enable/address/data/pending-load
//   flush                            drop slot contents and current input
//   out_valid/out_ready              ID/EXE slot handshake
//   out_src1/2, out_rfwa, out_ctrl   registered slot fields
//   hazard                           load-use stall this cycle
//   stall_cnt                        saturating count of hazard cycles
module stage_id_fwd #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int FWD_STAGES  = 2,
  parameter int CTRL_W      = 48,
  parameter int STALL_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REG_AW-1:0]            in_rs,
  input  logic [REG_AW-1:0]            in_rt,
  input  logic                         in_use_rs,
  input  logic                         in_use_rt,
  input  logic [REG_AW-1:0]            in_rfwa,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [DATA_W-1:0]            rf_rd1,
  input  logic [DATA_W-1:0]            rf_rd2,
  input  logic [FWD_STAGES-1:0]        fwd_we,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_wa,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_wd,
  input  logic [FWD_STAGES-1:0]        fwd_ld,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_src1,
  output logic [DATA_W-1:0]            out_src2,
  output logic [REG_AW-1:0]            out_rfwa,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic                         hazard,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  // Returns {hazardous, value}. The scan runs oldest to youngest so the
  // youngest matching stage is written last and wins, even if it is a load.
  function automatic logic [DATA_W:0] resolve(input logic [REG_AW-1:0] addr,
                                               input logic [DATA_W-1:0] rf_data);
    logic [DATA_W:0] r;
    r = {1'b0, rf_data};
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_wa[i*REG_AW +: REG_AW] == addr)) begin
        r = {fwd_ld[i], fwd_wd[i*DATA_W +: DATA_W]};
      end
    end
    // r0 is hardwired zero: never forwarded, never hazardous.
    if (addr == '0) begin
      r = '0;
    end
    return r;
  endfunction

  logic [DATA_W:0] rs_res;
  logic [DATA_W:0] rt_res;
  logic            adv;
  logic            accept;

  always_comb begin
    rs_res   = resolve(in_rs, rf_rd1);
    rt_res   = resolve(in_rt, rf_rd2);
    hazard   = in_valid & ((in_use_rs & rs_res[DATA_W]) | (in_use_rt & rt_res[DATA_W]));
    adv      = !out_valid | out_ready;
    in_ready = adv & !hazard & !flush;
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_src1  <= '0;
      out_src2  <= '0;
      out_rfwa  <= '0;
      out_ctrl  <= '0;
      stall_cnt <= '0;
    end else begin
      // Counts every hazard cycle, including those masked by flush or back-pressure.
      if (hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        out_valid <= in_valid & !hazard;
        if (accept) begin
          out_src1 <= rs_res[DATA_W-1:0];
          out_src2 <= rt_res[DATA_W-1:0];
          out_rfwa <= in_rfwa;
          out_ctrl <= in_ctrl;
        end
      end
    end
  end

endmodule
